// File: rtl/edc_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// edc_scrub_ctrl
//
// Background scrubber for main memory. Whenever scrubbing is enabled and the
// programmed idle interval has elapsed, it reads one word of the protected
// region. It passes the data and check word to the external combinational
// EDC corrector. If the corrector fixes the word, the corrected word is
// written back. Uncorrectable words are counted and raise a one-cycle IRQ.
// The scrubber owns the bus only from READ through CHECK/WRITE. It always
// lets a pending CPU request go first before it starts a new word.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_scrub_en              scrubbing enable (level)
//   i_interval              idle cycles between word scrubs
//   i_cpu_req               CPU wants the memory bus
//   o_bus_gnt               scrubber currently owns the bus
//   o_mem_req/_we/_adr/_dat memory access request, write flag, byte address,
//                           write data
//   i_mem_ack               one-cycle access-complete pulse
//   i_mem_dat, i_mem_ecc    read data and read check word
//   o_edcc_main_dat_w       captured data to the corrector
//   o_edcc_ecc_dat_w        captured check word to the corrector
//   i_edcc_dat_r            corrected data from the corrector
//   i_edcc_valid            corrector result usable (0 = uncorrectable)
//   o_corr_cnt              saturating count of corrected words
//   o_uncorr_cnt            saturating count of uncorrectable words
//   o_err_adr               address of the most recent erroneous word
//   o_irq                   one-cycle pulse on an uncorrectable word
// ---------------------------------------------------------------------------
module edc_scrub_ctrl #(
    parameter int WB_DWIDTH   = 32,
    parameter int WB_SWIDTH   = 4,
    parameter int AWIDTH      = 27,
    parameter int SCRUB_BASE  = 0,
    parameter int SCRUB_WORDS = 1024,
    parameter int IVL_W       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scrub_en,
    input  logic [IVL_W-1:0]     i_interval,
    input  logic                 i_cpu_req,
    output logic                 o_bus_gnt,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [AWIDTH-1:0]    o_mem_adr,
    output logic [WB_DWIDTH-1:0] o_mem_dat,
    input  logic                 i_mem_ack,
    input  logic [WB_DWIDTH-1:0] i_mem_dat,
    input  logic [WB_DWIDTH-1:0] i_mem_ecc,
    output logic [WB_DWIDTH-1:0] o_edcc_main_dat_w,
    output logic [WB_DWIDTH-1:0] o_edcc_ecc_dat_w,
    input  logic [WB_DWIDTH-1:0] i_edcc_dat_r,
    input  logic                 i_edcc_valid,
    output logic [15:0]          o_corr_cnt,
    output logic [15:0]          o_uncorr_cnt,
    output logic [AWIDTH-1:0]    o_err_adr,
    output logic                 o_irq
);

    localparam int PTR_W = (SCRUB_WORDS > 1) ? $clog2(SCRUB_WORDS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SCRUB_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_NEXT
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [IVL_W-1:0]       ivl_q, ivl_d;
    logic [WB_DWIDTH-1:0]   dat_q, dat_d;
    logic [WB_DWIDTH-1:0]   ecc_q, ecc_d;
    logic [WB_DWIDTH-1:0]   wdat_q, wdat_d;
    logic [15:0]            corr_q, corr_d;
    logic [15:0]            uncorr_q, uncorr_d;
    logic [AWIDTH-1:0]      err_adr_q, err_adr_d;

    logic                   gnt;
    logic                   req;
    logic                   we;
    logic                   irq;
    logic [AWIDTH-1:0]      cur_adr;

    assign cur_adr = AWIDTH'(SCRUB_BASE) + AWIDTH'(ptr_q) * AWIDTH'(WB_SWIDTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            ivl_q     <= '0;
            dat_q     <= '0;
            ecc_q     <= '0;
            wdat_q    <= '0;
            corr_q    <= '0;
            uncorr_q  <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ivl_q     <= ivl_d;
            dat_q     <= dat_d;
            ecc_q     <= ecc_d;
            wdat_q    <= wdat_d;
            corr_q    <= corr_d;
            uncorr_q  <= uncorr_d;
            err_adr_q <= err_adr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ivl_d     = ivl_q;
        dat_d     = dat_q;
        ecc_d     = ecc_q;
        wdat_d    = wdat_q;
        corr_d    = corr_q;
        uncorr_d  = uncorr_q;
        err_adr_d = err_adr_q;
        gnt       = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        irq       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_scrub_en) begin
                    state_d = S_WAIT;
                    ivl_d   = i_interval;
                end
            end

            S_WAIT: begin
                // The counter parks at zero while the CPU holds the bus
                // request. The scrubber only starts a word on a free bus.
                if (ivl_q == '0) begin
                    if (!i_cpu_req) begin
                        state_d = S_READ;
                    end
                end else begin
                    ivl_d = ivl_q - IVL_W'(1);
                end
            end

            S_READ: begin
                gnt = 1'b1;
                req = 1'b1;
                if (i_mem_ack) begin
                    dat_d   = i_mem_dat;
                    ecc_d   = i_mem_ecc;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                // The corrector is combinational on dat_q/ecc_q, so its result
                // is usable in this single cycle.
                gnt = 1'b1;
                if (!i_edcc_valid) begin
                    uncorr_d  = (uncorr_q == 16'hFFFF) ? uncorr_q : uncorr_q + 16'd1;
                    err_adr_d = cur_adr;
                    irq       = 1'b1;
                    state_d   = S_NEXT;
                end else if (i_edcc_dat_r != dat_q) begin
                    corr_d    = (corr_q == 16'hFFFF) ? corr_q : corr_q + 16'd1;
                    err_adr_d = cur_adr;
                    wdat_d    = i_edcc_dat_r;
                    state_d   = S_WRITE;
                end else begin
                    state_d = S_NEXT;
                end
            end

            S_WRITE: begin
                // Only data is written. The memory write path regenerates
                // the check bits.
                gnt = 1'b1;
                req = 1'b1;
                we  = 1'b1;
                if (i_mem_ack) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                if (i_scrub_en) begin
                    state_d = S_WAIT;
                    ivl_d   = i_interval;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_bus_gnt         = gnt;
    assign o_mem_req         = req;
    assign o_mem_we          = we;
    // The address is driven only while the bus is owned, so it reads as zero
    // in idle and in reset whatever the base address is.
    assign o_mem_adr         = gnt ? cur_adr : '0;
    assign o_mem_dat         = wdat_q;
    assign o_edcc_main_dat_w = dat_q;
    assign o_edcc_ecc_dat_w  = ecc_q;
    assign o_corr_cnt        = corr_q;
    assign o_uncorr_cnt      = uncorr_q;
    assign o_err_adr         = err_adr_q;
    assign o_irq             = irq;

endmodule

// File: tb/tb_edc_scrub_ctrl.sv
module tb_edc_scrub_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_scrub_en = 1'b0;
    logic [15:0] i_interval = 16'd0;
    logic        i_cpu_req = 1'b0;
    logic        o_bus_gnt;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [26:0] o_mem_adr;
    logic [31:0] o_mem_dat;
    logic        i_mem_ack;
    logic [31:0] i_mem_dat;
    logic [31:0] i_mem_ecc;
    logic [31:0] o_edcc_main_dat_w;
    logic [31:0] o_edcc_ecc_dat_w;
    logic [31:0] i_edcc_dat_r;
    logic        i_edcc_valid;
    logic [15:0] o_corr_cnt;
    logic [15:0] o_uncorr_cnt;
    logic [26:0] o_err_adr;
    logic        o_irq;

    // memory / corrector model
    logic [31:0] mem  [4];
    logic        bad  [4];
    logic        fixw [4];
    logic [31:0] fixv [4];
    logic        resp_en = 1'b1;
    logic        resp_ack = 1'b0;
    logic        tb_ack = 1'b0;
    logic [31:0] resp_dat = 32'h0;
    int          dly = 0;

    logic [26:0] rd_adr_q[$];
    logic [26:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    int          gap_q[$];
    int          irq_cnt = 0;
    int          req_cnt = 0;
    int          low_run = 0;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign i_mem_ack    = resp_ack | tb_ack;
    assign i_mem_dat    = resp_dat;
    assign i_mem_ecc    = ~resp_dat;
    assign i_edcc_valid = ~bad[o_mem_adr[3:2]];
    assign i_edcc_dat_r = fixw[o_mem_adr[3:2]] ? fixv[o_mem_adr[3:2]] : o_edcc_main_dat_w;

    edc_scrub_ctrl #(
        .WB_DWIDTH(32), .WB_SWIDTH(4), .AWIDTH(27),
        .SCRUB_BASE(0), .SCRUB_WORDS(4), .IVL_W(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scrub_en(i_scrub_en),
        .i_interval(i_interval), .i_cpu_req(i_cpu_req),
        .o_bus_gnt(o_bus_gnt), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
        .i_mem_ack(i_mem_ack), .i_mem_dat(i_mem_dat), .i_mem_ecc(i_mem_ecc),
        .o_edcc_main_dat_w(o_edcc_main_dat_w), .o_edcc_ecc_dat_w(o_edcc_ecc_dat_w),
        .i_edcc_dat_r(i_edcc_dat_r), .i_edcc_valid(i_edcc_valid),
        .o_corr_cnt(o_corr_cnt), .o_uncorr_cnt(o_uncorr_cnt),
        .o_err_adr(o_err_adr), .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    // Memory responder: acks each request on its second cycle, one line per transaction.
    always @(negedge i_clk) begin
        if (!i_rst_n || !resp_en) begin
            resp_ack = 1'b0;
            dly = 0;
        end else if (resp_ack) begin
            resp_ack = 1'b0;
            dly = 0;
        end else if (o_mem_req) begin
            if (dly == 1) begin
                resp_ack = 1'b1;
                dly = 0;
                if (o_mem_we) begin
                    wr_adr_q.push_back(o_mem_adr);
                    wr_dat_q.push_back(o_mem_dat);
                    $display("write adr=%h dat=%h", o_mem_adr, o_mem_dat);
                end else begin
                    resp_dat = mem[o_mem_adr[3:2]];
                    rd_adr_q.push_back(o_mem_adr);
                    $display("read  adr=%h dat=%h", o_mem_adr, resp_dat);
                end
            end else begin
                dly = dly + 1;
            end
        end
    end

    // Monitor: irq samples, req samples, length of each bus-free gap.
    always @(negedge i_clk) begin
        if (o_irq) irq_cnt = irq_cnt + 1;
        if (o_mem_req) req_cnt = req_cnt + 1;
        if (!o_bus_gnt) begin
            low_run = low_run + 1;
        end else begin
            if (low_run > 0) gap_q.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_scrub_en = 1'b0;
        i_cpu_req = 1'b0;
        tb_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bad[k] = 1'b0;
            fixw[k] = 1'b0;
        end
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic wait_q(input int sel, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            if ((sel == 0 ? rd_adr_q.size() : wr_adr_q.size()) >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_scrub_en = 1'b1;
        repeat (3) @(negedge i_clk);
        total_cnt++;
        if ({o_bus_gnt, o_mem_req, o_mem_we, o_irq} !== 4'b0)
            $display("FAIL reset_ctl: got %b expected 0000", {o_bus_gnt, o_mem_req, o_mem_we, o_irq});
        else pass_cnt++;
        total_cnt++;
        if ({o_mem_adr, o_err_adr} !== 54'h0)
            $display("FAIL reset_adr: got %h/%h expected 0/0", o_mem_adr, o_err_adr);
        else pass_cnt++;
        total_cnt++;
        if ({o_corr_cnt, o_uncorr_cnt} !== 32'h0)
            $display("FAIL reset_cnt: got %h/%h expected 0/0", o_corr_cnt, o_uncorr_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({o_mem_dat, o_edcc_main_dat_w, o_edcc_ecc_dat_w} !== 96'h0)
            $display("FAIL reset_dat: got %h/%h/%h expected 0", o_mem_dat, o_edcc_main_dat_w, o_edcc_ecc_dat_w);
        else pass_cnt++;
        i_scrub_en = 1'b0;
        i_rst_n = 1'b1;
    endtask

    task automatic test_clean_walk();
        int rb, wb, gb;
        bit ok;
        logic [26:0] exp_adr;
        do_reset();
        rb = rd_adr_q.size(); wb = wr_adr_q.size(); gb = gap_q.size();
        i_interval = 16'd3;
        i_scrub_en = 1'b1;
        wait_q(0, rb + 5, 300, ok);
        repeat (3) @(negedge i_clk);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL walk_timeout: got %0d reads required 5", rd_adr_q.size() - rb);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            exp_adr = 27'((k % 4) * 4);
            total_cnt++;
            if (rd_adr_q[rb + k] !== exp_adr)
                $display("FAIL walk_adr%0d: got %h expected %h", k, rd_adr_q[rb + k], exp_adr);
            else pass_cnt++;
        end
        for (int k = 1; k < 5; k++) begin
            total_cnt++;
            if (gap_q[gb + k] !== 5)
                $display("FAIL walk_gap%0d: got %0d idle cycles expected 5", k, gap_q[gb + k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (wr_adr_q.size() - wb !== 0)
            $display("FAIL walk_writes: got %0d expected 0", wr_adr_q.size() - wb);
        else pass_cnt++;
        total_cnt++;
        if ({o_corr_cnt, o_uncorr_cnt} !== 32'h0)
            $display("FAIL walk_cnt: got %h/%h expected 0/0", o_corr_cnt, o_uncorr_cnt);
        else pass_cnt++;
        total_cnt++;
        if (o_edcc_main_dat_w !== mem[0] || o_edcc_ecc_dat_w !== ~mem[0])
            $display("FAIL walk_capture: got %h/%h expected %h/%h",
                     o_edcc_main_dat_w, o_edcc_ecc_dat_w, mem[0], ~mem[0]);
        else pass_cnt++;
        i_scrub_en = 1'b0;
    endtask

    task automatic test_correctable();
        int rb, wb, ib;
        bit ok;
        do_reset();
        rb = rd_adr_q.size(); wb = wr_adr_q.size(); ib = irq_cnt;
        mem[2] = 32'hDEADBEEF;
        fixw[2] = 1'b1;
        fixv[2] = 32'hDEADBEFF;
        i_interval = 16'd3;
        i_scrub_en = 1'b1;
        wait_q(1, wb + 1, 300, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL corr_timeout: got 0 writes required 1");
        else pass_cnt++;
        total_cnt++;
        if (wr_adr_q[wb] !== 27'h8) $display("FAIL corr_wadr: got %h expected 008", wr_adr_q[wb]);
        else pass_cnt++;
        total_cnt++;
        if (wr_dat_q[wb] !== 32'hDEADBEFF) $display("FAIL corr_wdat: got %h expected deadbeff", wr_dat_q[wb]);
        else pass_cnt++;
        total_cnt++;
        if (rd_adr_q.size() - rb !== 3) $display("FAIL corr_reads: got %0d expected 3", rd_adr_q.size() - rb);
        else pass_cnt++;
        total_cnt++;
        if (o_corr_cnt !== 16'd1 || o_uncorr_cnt !== 16'd0)
            $display("FAIL corr_cnt: got %0d/%0d expected 1/0", o_corr_cnt, o_uncorr_cnt);
        else pass_cnt++;
        total_cnt++;
        if (o_err_adr !== 27'h8) $display("FAIL corr_erradr: got %h expected 008", o_err_adr);
        else pass_cnt++;
        total_cnt++;
        if (irq_cnt - ib !== 0) $display("FAIL corr_irq: got %0d pulses expected 0", irq_cnt - ib);
        else pass_cnt++;
        i_scrub_en = 1'b0;
    endtask

    task automatic test_uncorrectable();
        int rb, wb, ib;
        bit ok;
        do_reset();
        rb = rd_adr_q.size(); wb = wr_adr_q.size(); ib = irq_cnt;
        bad[1] = 1'b1;
        i_interval = 16'd3;
        i_scrub_en = 1'b1;
        wait_q(0, rb + 2, 300, ok);
        repeat (4) @(negedge i_clk);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL unc_timeout: got %0d reads required 2", rd_adr_q.size() - rb);
        else pass_cnt++;
        total_cnt++;
        if (o_uncorr_cnt !== 16'd1 || o_corr_cnt !== 16'd0)
            $display("FAIL unc_cnt: got %0d/%0d expected 1/0", o_uncorr_cnt, o_corr_cnt);
        else pass_cnt++;
        total_cnt++;
        if (o_err_adr !== 27'h4) $display("FAIL unc_erradr: got %h expected 004", o_err_adr);
        else pass_cnt++;
        total_cnt++;
        if (irq_cnt - ib !== 1) $display("FAIL unc_irq: got %0d irq cycles expected 1", irq_cnt - ib);
        else pass_cnt++;
        wait_q(0, rb + 3, 100, ok);
        total_cnt++;
        if (rd_adr_q[rb + 2] !== 27'h8) $display("FAIL unc_next: got %h expected 008", rd_adr_q[rb + 2]);
        else pass_cnt++;
        total_cnt++;
        if (wr_adr_q.size() - wb !== 0) $display("FAIL unc_writes: got %0d expected 0", wr_adr_q.size() - wb);
        else pass_cnt++;
        i_scrub_en = 1'b0;
    endtask

    task automatic test_cpu_yield();
        int rb, qb;
        bit ok;
        bit seen;
        do_reset();
        rb = rd_adr_q.size(); qb = req_cnt;
        i_cpu_req = 1'b1;
        i_interval = 16'd3;
        i_scrub_en = 1'b1;
        repeat (30) @(negedge i_clk);
        total_cnt++;
        if (req_cnt - qb !== 0) $display("FAIL cpu_hold: got %0d req cycles expected 0", req_cnt - qb);
        else pass_cnt++;
        i_cpu_req = 1'b0;
        wait_q(0, rb + 1, 20, ok);
        total_cnt++;
        if (ok !== 1'b1 || rd_adr_q[rb] !== 27'h0)
            $display("FAIL cpu_release: got ok=%0d adr=%h expected 1/000", ok, rd_adr_q[rb]);
        else pass_cnt++;
        // raise cpu_req in the middle of the next read
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_clk);
            if (o_mem_req && !o_mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        i_cpu_req = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_clk);
            if (!o_bus_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        total_cnt++;
        if ((seen & ok) !== 1'b1) $display("FAIL cpu_midread: got seen=%0d released=%0d expected 1/1", seen, ok);
        else pass_cnt++;
        total_cnt++;
        if (rd_adr_q.size() - rb !== 2) $display("FAIL cpu_complete: got %0d reads expected 2", rd_adr_q.size() - rb);
        else pass_cnt++;
        qb = req_cnt;
        repeat (20) @(negedge i_clk);
        total_cnt++;
        if (req_cnt - qb !== 0 || rd_adr_q.size() - rb !== 2)
            $display("FAIL cpu_yield: got %0d req cycles expected 0", req_cnt - qb);
        else pass_cnt++;
        i_cpu_req = 1'b0;
        i_scrub_en = 1'b0;
    endtask

    task automatic test_en_drop_write();
        int rb, wb;
        bit ok;
        do_reset();
        rb = rd_adr_q.size(); wb = wr_adr_q.size();
        fixw[0] = 1'b1;
        fixv[0] = mem[0] ^ 32'h1;
        i_interval = 16'd0;
        i_scrub_en = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            if (o_mem_we) begin
                ok = 1'b1;
                break;
            end
        end
        i_scrub_en = 1'b0;
        repeat (15) @(negedge i_clk);
        total_cnt++;
        if (ok !== 1'b1 || wr_adr_q.size() - wb !== 1)
            $display("FAIL endrop_write: got ok=%0d writes=%0d expected 1/1", ok, wr_adr_q.size() - wb);
        else pass_cnt++;
        total_cnt++;
        if (wr_adr_q[wb] !== 27'h0 || wr_dat_q[wb] !== fixv[0])
            $display("FAIL endrop_wdata: got %h/%h expected 000/%h", wr_adr_q[wb], wr_dat_q[wb], fixv[0]);
        else pass_cnt++;
        total_cnt++;
        if (rd_adr_q.size() - rb !== 1 || o_bus_gnt !== 1'b0)
            $display("FAIL endrop_idle: got reads=%0d gnt=%b expected 1/0", rd_adr_q.size() - rb, o_bus_gnt);
        else pass_cnt++;
        fixw[0] = 1'b0;
        i_scrub_en = 1'b1;
        wait_q(0, rb + 2, 30, ok);
        total_cnt++;
        if (ok !== 1'b1 || rd_adr_q[rb + 1] !== 27'h4)
            $display("FAIL endrop_resume: got ok=%0d adr=%h expected 1/004", ok, rd_adr_q[rb + 1]);
        else pass_cnt++;
        i_scrub_en = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int ib;
        bit ok;
        do_reset();
        resp_en = 1'b0;
        i_interval = 16'd0;
        i_scrub_en = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            if (o_mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        total_cnt++;
        if (ok !== 1'b1 || {o_mem_req, o_bus_gnt} !== 2'b00 || o_mem_adr !== 27'h0)
            $display("FAIL rst_async: got ok=%0d req=%b gnt=%b adr=%h expected 1/0/0/000",
                     ok, o_mem_req, o_bus_gnt, o_mem_adr);
        else pass_cnt++;
        @(negedge i_clk);
        i_scrub_en = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        ib = irq_cnt;
        repeat (2) @(negedge i_clk);
        tb_ack = 1'b1;
        @(negedge i_clk);
        tb_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        total_cnt++;
        if ({o_mem_req, o_bus_gnt} !== 2'b00 || o_edcc_main_dat_w !== 32'h0)
            $display("FAIL rst_stray_idle: got req=%b gnt=%b cap=%h expected 0/0/0",
                     o_mem_req, o_bus_gnt, o_edcc_main_dat_w);
        else pass_cnt++;
        i_interval = 16'd20;
        i_scrub_en = 1'b1;
        repeat (3) @(negedge i_clk);
        tb_ack = 1'b1;
        @(negedge i_clk);
        tb_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        total_cnt++;
        if (o_bus_gnt !== 1'b0 || o_edcc_main_dat_w !== 32'h0)
            $display("FAIL rst_stray_wait: got gnt=%b cap=%h expected 0/0", o_bus_gnt, o_edcc_main_dat_w);
        else pass_cnt++;
        total_cnt++;
        if ({o_corr_cnt, o_uncorr_cnt} !== 32'h0 || irq_cnt - ib !== 0)
            $display("FAIL rst_stray_cnt: got %0d/%0d irq=%0d expected 0/0/0",
                     o_corr_cnt, o_uncorr_cnt, irq_cnt - ib);
        else pass_cnt++;
        i_scrub_en = 1'b0;
        resp_en = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mem[k]  = 32'hC0DE_0001 + 32'(k);
            bad[k]  = 1'b0;
            fixw[k] = 1'b0;
            fixv[k] = 32'h0;
        end
        test_reset();
        test_clean_walk();
        test_correctable();
        test_uncorrectable();
        test_cpu_yield();
        test_en_drop_write();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/edc_scrub_ctrl.md
Name: edc_scrub_ctrl

Overview:
- Background memory scrubber and EDC sequencer for the 128 MB main memory.
- Walks the protected region one word at a time, whenever the bus is idle and the programmed interval has elapsed.
- Each word's data and check bits are fed through the EDC corrector (edcc_mod, instantiated outside this block). Words the corrector fixes are written back; uncorrectable words are logged.
- Sits beside the Wishbone master. It yields to the CPU whenever the CPU wants the bus.

Parameters:
- WB_DWIDTH, 32, data word width (bits).
- WB_SWIDTH, 4, byte selects per word; the address step is WB_SWIDTH.
- AWIDTH, 27, byte address width (128 MB).
- SCRUB_BASE, 0, first byte address scrubbed (word aligned).
- SCRUB_WORDS, 1024, number of words in the scrub region; must be ≥1.
- IVL_W, 16, width of the interval counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_scrub_en  in  1  scrub enable (level)
- i_interval  in  IVL_W  idle cycles between word scrubs
- i_cpu_req  in  1  CPU wants the memory bus
- o_bus_gnt  out  1  scrubber owns the bus
- o_mem_req  out  1  memory access request
- o_mem_we  out  1  1 = write
- o_mem_adr  out  AWIDTH  byte address
- o_mem_dat  out  WB_DWIDTH  write data
- i_mem_ack  in  1  access complete (one-cycle pulse)
- i_mem_dat  in  WB_DWIDTH  read data
- i_mem_ecc  in  WB_DWIDTH  read check word
- o_edcc_main_dat_w  out  WB_DWIDTH  to corrector edcc_main_dat_w
- o_edcc_ecc_dat_w  out  WB_DWIDTH  to corrector edcc_ecc_dat_w
- i_edcc_dat_r  in  WB_DWIDTH  corrected data from the corrector
- i_edcc_valid  in  1  corrector result usable (0 = uncorrectable)
- o_corr_cnt  out  16  corrected-error count, saturating
- o_uncorr_cnt  out  16  uncorrectable-error count, saturating
- o_err_adr  out  AWIDTH  address of the last erroneous word
- o_irq  out  1  one-cycle pulse on an uncorrectable error

Behaviour:
- Reset: one clock domain. i_rst_n is asynchronous and active-low.
  - While reset is asserted: all outputs 0, state IDLE, word pointer 0, interval counter 0.
- States and transitions:
  - IDLE: wait for i_scrub_en=1, then go to WAIT and load the counter with i_interval.
  - WAIT: decrement the counter each cycle.
    - At 0 with i_cpu_req=0: go to READ.
    - At 0 with i_cpu_req=1: hold at 0 until i_cpu_req=0.
  - READ: o_bus_gnt=1, o_mem_req=1, o_mem_we=0, o_mem_adr = SCRUB_BASE + ptr*WB_SWIDTH.
    - Hold all of these stable until i_mem_ack.
    - On ack, capture i_mem_dat and i_mem_ecc into registers, drop req, go to CHECK.
  - CHECK: one cycle.
    - The captured registers drive o_edcc_*_dat_w; the corrector is combinational.
    - If i_edcc_valid=0: uncorr_cnt+1, o_err_adr = current address, o_irq=1 for this cycle, go to NEXT.
    - Else if i_edcc_dat_r ≠ captured data: corr_cnt+1, o_err_adr = current address, latch i_edcc_dat_r into o_mem_dat, go to WRITE.
    - Else: go to NEXT.
  - WRITE: o_mem_req=1, o_mem_we=1, same address, o_mem_dat = corrected word. On i_mem_ack go to NEXT.
    - Check bits are regenerated by the memory write path.
  - NEXT: drop o_bus_gnt; ptr = ptr+1, wrapping to 0 after SCRUB_WORDS-1.
    - i_scrub_en=1: go to WAIT and reload i_interval.
    - i_scrub_en=0: go to IDLE.
- Bus rules:
  - o_bus_gnt is 1 only in READ, CHECK and WRITE.
  - A read→CHECK→write-back sequence is atomic: i_cpu_req is ignored until NEXT. This gives the CPU a worst-case wait of two memory accesses plus 2 cycles.
- i_scrub_en deasserted mid-operation: the word in progress completes through NEXT, then the block goes to IDLE. The pointer is kept, so scrubbing resumes where it stopped.
- i_interval=0: READ follows NEXT after one WAIT cycle.
- Counters saturate at 16'hFFFF and clear only on reset.
- An ack arriving outside READ/WRITE is ignored.
- Asynchronous reset mid-access drops o_mem_req immediately. A later stray ack is ignored.

Test Plan:
1. SCRUB_WORDS=4, i_interval=3, clean memory, en=1 → four reads at 0x0, 0x4, 0x8, 0xC, then 0x0 again; no writes; counts stay 0; 4 WAIT cycles between each NEXT and the following READ.
2. Word 0x8 stored 0xDEADBEEF with single-bit ECC error; corrector returns 0xDEADBEFF valid → write to 0x8 with data 0xDEADBEFF; corr_cnt=1; o_err_adr=0x8; o_irq stays 0.
3. Word 0x4 uncorrectable (i_edcc_valid=0) → no write; uncorr_cnt=1; o_irq high for exactly one cycle; o_err_adr=0x4.
4. i_cpu_req held high when the counter reaches 0 → no o_mem_req until i_cpu_req falls. i_cpu_req raised during READ → the scrub completes, and o_bus_gnt falls in NEXT.
5. en dropped during WRITE → write completes, block enters IDLE. en reasserted → next read is at the following address.
6. i_rst_n low while o_mem_req=1 and ack pending → outputs 0 asynchronously. After release, a stray ack is ignored and counts stay 0.
